ext_mem_arbiter: RTL and testbench
==================================

# ext_mem_arbiter

Shares the single external RAM port (mem_r_* / mem_w_*) between the first and second memory buffers' mode-0 loaders. Each requester posts a burst descriptor (direction, lane mask, base address, length). The arbiter grants one requester at a time using round-robin, generates consecutive addresses, moves the data, and signals completion. It sits between the controller-side buffer loaders and the top-level external memory ports of inference_accelerator.

## Interface
Parameters:
- N_PE, default `N_PE: lane count; width of the mem_r_en / mem_w_en lane masks.
- ADDR_RAM, default `ADDR_RAM: external address width.
- WID_RAM, default `WID_RAM: external data width.
- LEN_W, default `ARB_LEN_BITS (8): burst length field width.

Ports:
- clk, in, 1: single clock; all state changes on rising edge.
- rst, in, 1: asynchronous, active-low reset.
- req, in, 2: bit i = requester i wants the port (0 = first buffer, 1 = second buffer).
- req_we, in, 2: 1 = write burst, 0 = read burst.
- req_lane, in, 2*N_PE: per-requester lane mask, slice i at [i*N_PE +: N_PE].
- req_addr, in, 2*ADDR_RAM: burst base address per requester.
- req_len, in, 2*LEN_W: beats per burst, 0..2^LEN_W-1.
- w_data, in, 2*WID_RAM: write data per requester.
- gnt, out, 2: one-hot grant, held for the whole transaction.
- beat, out, 2: one-cycle strobe per beat. On a write, w_data is consumed this cycle; on a read, an address is issued this cycle.
- r_valid, out, 2: read data valid for requester i.
- r_data, out, WID_RAM: read data, shared by both requesters.
- done, out, 2: one-cycle completion pulse.
- busy, out, 1: state is not IDLE.
- mem_r_en, out, N_PE; mem_r_addr, out, ADDR_RAM; mem_r_data, in, WID_RAM.
- mem_w_en, out, N_PE; mem_w_addr, out, ADDR_RAM; mem_w_data, out, WID_RAM.

## Operation
- FSM states: IDLE, BURST, DRAIN, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: latch the winner's descriptor and move to BURST. If req_len = 0, go directly to DONE instead.
- BURST: one beat per cycle; cnt runs 0..len-1.
  - Read: mem_r_en = lane, mem_r_addr = base+cnt.
  - Write: mem_w_en = lane, mem_w_addr = base+cnt, mem_w_data = w_data[winner].
  - Last beat: a write goes to DONE; a read goes to DRAIN.
- DRAIN (read only): one cycle, captures the final read word, then goes to DONE.
- DONE: done[winner] = 1 and gnt is still held; next state IDLE.
- Round-robin: register `last` records the most recently granted requester; its reset value is 1, so requester 0 wins first. When both request in IDLE, the requester other than `last` wins. A single requester always wins.
- Descriptors are latched at grant. Requester inputs other than w_data are ignored during BURST, DRAIN and DONE.
- A req still high in the cycle after DONE is treated as a new request.
- Address arithmetic is base+cnt modulo 2^ADDR_RAM; wrap-around is silent.
- The external RAM has a fixed 1-cycle read latency.
  - r_valid[winner] is beat[winner] delayed by one cycle.
  - r_data = mem_r_data, combinational pass-through.
- mem_r_en and mem_w_en are never asserted together; lanes are 0 outside BURST.
- Reset, including mid-burst: state = IDLE, last = 1. gnt, beat, r_valid, done, busy, mem_*_en, mem_*_addr and mem_w_data are all 0 while rst is low and immediately after. An interrupted burst is abandoned, with no done pulse.

## Timing
- req rises in IDLE at cycle t → gnt and first beat at t+1.
- Write, len L: beats at t+1..t+L, done at t+L+1, IDLE at t+L+2. The earliest next grant is t+L+3.
- Read, len L: beats at t+1..t+L, r_valid at t+2..t+L+1 (the last in DRAIN), done at t+L+2.
- len 0: gnt and done both at t+1, with no memory access.
- Only combinational path from inputs to outputs: w_data → mem_w_data, and mem_r_data → r_data. Every other output is a function of registers only.

## Structure
- In header.vh: `ARB_LEN_BITS and the state encodings `ARB_IDLE, `ARB_BURST, `ARB_DRAIN, `ARB_DONE (2 bits).
- One sub-module, ext_burst_gen: loads base/len and emits cnt, addr and last_beat. The FSM and round-robin logic stay in ext_mem_arbiter.

## Test plan
- Reset mid-burst: assert rst low during BURST → all outputs 0 and no done; after release, a req on 1 alone is granted normally.
- Single write: req0 write, lane=8'h0F, addr=0x010, len=4 → mem_w_addr 0x010..0x013 on consecutive cycles, mem_w_en=0x0F, done[0] at the 5th cycle after grant request.
- Single read: req1 read, addr=0x3FE with ADDR_RAM=10, len=3 → addresses 0x3FE, 0x3FF, 0x000 (wrap); r_valid[1] three cycles each carrying the RAM model's data; done[1] one cycle after the last r_valid.
- Contention: req=2'b11 held continuously, len=2 each → grants alternate 0,1,0,1 with no overlap and mem_r_en & mem_w_en never both nonzero.
- len=0: req0, len=0 → gnt[0] and done[0] in the same cycle with no mem enables, and busy is high for exactly 1 cycle.

Source files
------------

// File: rtl/ext_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_arbiter_pkg
// Purpose  : Shared types and constants for the external-memory arbiter.
//            Holds default widths, the burst-length field width and the
//            arbiter state encoding, plus a one-hot helper for the two
//            requester ports.
// Revision : 1.0 - initial release
// ============================================================================
package ext_mem_arbiter_pkg;

  localparam int N_PE_DEF     = 8;   // lane count
  localparam int ADDR_RAM_DEF = 10;  // external address width
  localparam int WID_RAM_DEF  = 16;  // external data width
  localparam int ARB_LEN_BITS = 8;   // burst length field width

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_DRAIN = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // Requester index (0/1) to its one-hot position in a 2-bit vector.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_arbiter_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : ext_burst_gen
// Purpose  : Burst address generator. Captures base address and length on
//            load, then steps a beat counter on each advance. The address is
//            base+cnt modulo 2^ADDR_W (wrap-around is silent).
// Ports    : clk, rst (async, active-low)
//            load_i / base_i / len_i : capture a new descriptor, cnt -> 0
//            adv_i                   : step to the next beat
//            addr_o                  : current beat address
//            last_beat_o             : current beat is the final one
// Revision : 1.0 - initial release
// ============================================================================
module ext_burst_gen #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_beat_o
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      base_q <= base_i;
      len_q  <= len_i;
      cnt_q  <= '0;
    end else if (adv_i) begin
      cnt_q  <= cnt_q + LEN_W'(1);
    end
  end

  assign addr_o      = base_q + ADDR_W'(cnt_q);
  // A zero-length burst never reaches the BURST state, so len_q-1 is only
  // evaluated meaningfully for len_q >= 1.
  assign last_beat_o = (cnt_q == (len_q - LEN_W'(1)));

endmodule
`default_nettype wire

// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_arbiter
// Purpose  : Shares one external RAM port between two burst requesters
//            (first / second buffer loaders) with round-robin arbitration.
//            A granted descriptor is latched, beats are issued one per
//            cycle, reads get one DRAIN cycle for the 1-cycle RAM latency,
//            and a DONE cycle pulses done[winner].
// Ports    : clk, rst (async, active-low)
//            req/req_we/req_lane/req_addr/req_len/w_data : requester side
//            gnt/beat/r_valid/r_data/done/busy          : requester status
//            mem_r_* / mem_w_*                          : external RAM port
// Revision : 1.0 - initial release
// ============================================================================
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int N_PE     = N_PE_DEF,
  parameter int ADDR_RAM = ADDR_RAM_DEF,
  parameter int WID_RAM  = WID_RAM_DEF,
  parameter int LEN_W    = ARB_LEN_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            req_we,
  input  logic [2*N_PE-1:0]     req_lane,
  input  logic [2*ADDR_RAM-1:0] req_addr,
  input  logic [2*LEN_W-1:0]    req_len,
  input  logic [2*WID_RAM-1:0]  w_data,
  output logic [1:0]            gnt,
  output logic [1:0]            beat,
  output logic [1:0]            r_valid,
  output logic [WID_RAM-1:0]    r_data,
  output logic [1:0]            done,
  output logic                  busy,
  output logic [N_PE-1:0]       mem_r_en,
  output logic [ADDR_RAM-1:0]   mem_r_addr,
  input  logic [WID_RAM-1:0]    mem_r_data,
  output logic [N_PE-1:0]       mem_w_en,
  output logic [ADDR_RAM-1:0]   mem_w_addr,
  output logic [WID_RAM-1:0]    mem_w_data
);

  arb_state_e        state_q;
  logic              winner_q;   // requester owning the current transaction
  logic              last_q;     // most recently granted requester
  logic              we_q;
  logic [N_PE-1:0]   lane_q;
  logic [1:0]        gnt_q;
  logic [1:0]        beat_q;
  logic [1:0]        done_q;
  logic [1:0]        rvalid_q;
  logic              busy_q;

  logic                win_d;
  logic [LEN_W-1:0]    len_d;
  logic [ADDR_RAM-1:0] base_d;
  logic [N_PE-1:0]     lane_d;
  logic                load_d;
  logic                adv_d;
  logic [ADDR_RAM-1:0] burst_addr;
  logic                burst_last;
  logic                rd_act;
  logic                wr_act;

  // Round-robin: on contention the requester that did not go last wins;
  // a lone requester always wins.
  always_comb begin
    win_d  = (req == 2'b11) ? ~last_q : req[1];
    len_d  = win_d ? req_len[2*LEN_W-1 -: LEN_W]     : req_len[LEN_W-1:0];
    base_d = win_d ? req_addr[2*ADDR_RAM-1 -: ADDR_RAM] : req_addr[ADDR_RAM-1:0];
    lane_d = win_d ? req_lane[2*N_PE-1 -: N_PE]      : req_lane[N_PE-1:0];
    load_d = (state_q == ARB_IDLE) && (|req);
    adv_d  = (state_q == ARB_BURST);
  end

  ext_burst_gen #(
    .ADDR_W (ADDR_RAM),
    .LEN_W  (LEN_W)
  ) u_burst_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_d),
    .base_i      (base_d),
    .len_i       (len_d),
    .adv_i       (adv_d),
    .addr_o      (burst_addr),
    .last_beat_o (burst_last)
  );

  // Control FSM; status outputs are registered alongside the state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      winner_q <= 1'b0;
      last_q   <= 1'b1;   // requester 0 wins the first contention
      we_q     <= 1'b0;
      lane_q   <= '0;
      gnt_q    <= '0;
      beat_q   <= '0;
      done_q   <= '0;
      rvalid_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            winner_q <= win_d;
            last_q   <= win_d;
            we_q     <= req_we[win_d];
            lane_q   <= lane_d;
            gnt_q    <= onehot2(win_d);
            busy_q   <= 1'b1;
            if (len_d == '0) begin
              state_q <= ARB_DONE;
              done_q  <= onehot2(win_d);
            end else begin
              state_q <= ARB_BURST;
              beat_q  <= onehot2(win_d);
            end
          end
        end
        ARB_BURST: begin
          if (burst_last) begin
            beat_q <= '0;
            if (we_q) begin
              state_q <= ARB_DONE;
              done_q  <= onehot2(winner_q);
            end else begin
              state_q <= ARB_DRAIN;
            end
          end
        end
        ARB_DRAIN: begin
          state_q <= ARB_DONE;
          done_q  <= onehot2(winner_q);
        end
        ARB_DONE: begin
          state_q <= ARB_IDLE;
          done_q  <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ARB_IDLE;
      endcase
      // RAM returns data one cycle after the address beat.
      rvalid_q <= we_q ? 2'b00 : beat_q;
    end
  end

  assign rd_act = (state_q == ARB_BURST) && !we_q;
  assign wr_act = (state_q == ARB_BURST) &&  we_q;

  assign gnt        = gnt_q;
  assign beat       = beat_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign r_valid    = rvalid_q;
  assign r_data     = mem_r_data;
  assign mem_r_en   = rd_act ? lane_q     : '0;
  assign mem_r_addr = rd_act ? burst_addr : '0;
  assign mem_w_en   = wr_act ? lane_q     : '0;
  assign mem_w_addr = wr_act ? burst_addr : '0;
  assign mem_w_data = !wr_act ? '0 :
                      (winner_q ? w_data[2*WID_RAM-1 -: WID_RAM] : w_data[WID_RAM-1:0]);

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_mem_arbiter
// Purpose  : Self-checking bench for ext_mem_arbiter. A transaction-level
//            model expands each grant into a list of expected per-cycle
//            output records; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_mem_arbiter;

  localparam int NP = 8;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req;
  logic [1:0]      req_we;
  logic [2*NP-1:0] req_lane;
  logic [2*AW-1:0] req_addr;
  logic [2*LW-1:0] req_len;
  logic [2*DW-1:0] w_data;
  logic [1:0]      gnt, beat, r_valid, done;
  logic [DW-1:0]   r_data;
  logic            busy;
  logic [NP-1:0]   mem_r_en, mem_w_en;
  logic [AW-1:0]   mem_r_addr, mem_w_addr;
  logic [DW-1:0]   mem_r_data = '0;
  logic [DW-1:0]   mem_w_data;

  ext_mem_arbiter #(.N_PE(NP), .ADDR_RAM(AW), .WID_RAM(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_lane(req_lane),
    .req_addr(req_addr), .req_len(req_len), .w_data(w_data), .gnt(gnt),
    .beat(beat), .r_valid(r_valid), .r_data(r_data), .done(done), .busy(busy),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data)
  );

  always #5 clk = ~clk;

  // RAM contents are a fixed function of the address; 1-cycle read latency.
  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {22'd0, a} * 32'd40503 + 32'h1234;
    return t[DW-1:0] ^ t[31:16];
  endfunction

  always @(posedge clk) if (mem_r_en != '0) mem_r_data <= ram_f(mem_r_addr);

  typedef struct packed {
    logic [1:0]    gnt, beat, rv, done;
    logic          busy;
    logic [NP-1:0] ren, wen;
    logic [AW-1:0] raddr, waddr;
    logic          wsel_v, wsel, rchk;
    logic [DW-1:0] rdat;
  } exp_t;

  exp_t cur;
  exp_t q[$];
  int   last_m;
  int   errors = 0;
  int   checks = 0;
  logic [1:0] prev_gnt = '0;
  logic [1:0] gstarts[$];

  function automatic exp_t idle_rec();
    exp_t r;
    r = '0;
    return r;
  endfunction

  function automatic logic [63:0] act_vec();
    return {3'd0, gnt, beat, r_valid, done, busy, mem_r_en, mem_w_en,
            mem_r_addr, mem_w_addr, mem_w_data};
  endfunction

  task automatic model_reset();
    q.delete();
    cur    = idle_rec();
    last_m = 1;
  endtask

  // Expand one granted descriptor into its expected cycle-by-cycle outputs.
  task automatic model_grant();
    int w, L;
    logic we;
    logic [NP-1:0] lane;
    logic [AW-1:0] base, a, pa;
    logic [1:0] g;
    exp_t r;
    w      = (req == 2'b11) ? 1 - last_m : (req[0] ? 0 : 1);
    last_m = w;
    we     = req_we[w];
    lane   = req_lane[w*NP +: NP];
    base   = req_addr[w*AW +: AW];
    L      = int'(req_len[w*LW +: LW]);
    g      = 2'b01 << w;
    pa     = '0;
    for (int k = 0; k < L; k++) begin
      r = idle_rec();
      r.gnt = g; r.beat = g; r.busy = 1'b1;
      a = AW'(int'(base) + k);
      if (we) begin
        r.wen = lane; r.waddr = a; r.wsel_v = 1'b1; r.wsel = w[0];
      end else begin
        r.ren = lane; r.raddr = a;
        if (k > 0) begin r.rv = g; r.rchk = 1'b1; r.rdat = ram_f(pa); end
      end
      pa = a;
      q.push_back(r);
    end
    if (!we && L > 0) begin
      r = idle_rec();
      r.gnt = g; r.busy = 1'b1; r.rv = g; r.rchk = 1'b1; r.rdat = ram_f(pa);
      q.push_back(r);
    end
    r = idle_rec();
    r.gnt = g; r.done = g; r.busy = 1'b1;
    q.push_back(r);
  endtask

  // Decide the next cycle's expectation from the inputs about to be sampled.
  task automatic model_advance();
    if (q.size() > 0)            cur = q.pop_front();
    else if (!cur.busy && req != 2'b00) begin
      model_grant();
      cur = q.pop_front();
    end else                     cur = idle_rec();
  endtask

  task automatic compare();
    logic [DW-1:0] wd;
    logic [63:0]   e;
    wd = !cur.wsel_v ? '0 : (cur.wsel ? w_data[2*DW-1:DW] : w_data[DW-1:0]);
    e  = {3'd0, cur.gnt, cur.beat, cur.rv, cur.done, cur.busy, cur.ren, cur.wen,
          cur.raddr, cur.waddr, wd};
    checks++;
    if (act_vec() !== e) begin
      errors++;
      $display("FAIL outputs @%0t: got gnt=%b beat=%b rv=%b done=%b busy=%b ren=%h wen=%h ra=%h wa=%h wd=%h | need gnt=%b beat=%b rv=%b done=%b busy=%b ren=%h wen=%h ra=%h wa=%h wd=%h",
               $time, gnt, beat, r_valid, done, busy, mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data,
               cur.gnt, cur.beat, cur.rv, cur.done, cur.busy, cur.ren, cur.wen, cur.raddr, cur.waddr, wd);
    end
    if (cur.rchk) begin
      checks++;
      if (r_data !== cur.rdat) begin
        errors++;
        $display("FAIL r_data @%0t: got %h need %h", $time, r_data, cur.rdat);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s @%0t: got %h need %h", name, $time, got, need);
    end
  endtask

  // One clock: model the coming edge, let the DUT take it, compare at negedge.
  task automatic cyc();
    w_data = {16'($urandom), 16'($urandom)};
    model_advance();
    @(posedge clk);
    @(negedge clk);
    compare();
    if (gnt != 2'b00 && prev_gnt == 2'b00) gstarts.push_back(gnt);
    prev_gnt = gnt;
  endtask

  task automatic rand_inputs();
    req    = 2'($urandom_range(0, 3));
    req_we = 2'($urandom);
    for (int i = 0; i < 2; i++) begin
      req_lane[i*NP +: NP] = NP'($urandom_range(1, 255));
      req_addr[i*AW +: AW] = AW'($urandom);
      req_len[i*LW +: LW]  = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 40))
                                                          : LW'($urandom_range(0, 5));
    end
  endtask

  task automatic set_slot(input int i, input logic we, input logic [NP-1:0] lane,
                          input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req_we[i]            = we;
    req_lane[i*NP +: NP] = lane;
    req_addr[i*AW +: AW] = addr;
    req_len[i*LW +: LW]  = len;
  endtask

  task automatic wait_idle();
    req = 2'b00;
    for (int n = 0; n < 100 && (q.size() > 0 || cur.busy); n++) cyc();
    cyc();
  endtask

  logic [AW-1:0] wr_lit[4];
  logic [AW-1:0] rd_lit[3];
  logic [1:0]    g_lit[4];

  initial begin
    wr_lit = '{10'h010, 10'h011, 10'h012, 10'h013};
    rd_lit = '{10'h3FE, 10'h3FF, 10'h000};
    g_lit  = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b0; req = '0; req_we = '0; req_lane = '0; req_addr = '0;
    req_len = '0; w_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();                          // reset state
    rst = 1'b1;

    // Reset in the middle of a burst: everything clears, no done pulse.
    req = 2'b01; set_slot(0, 1'b1, 8'hFF, 10'h100, 8'd6);
    cyc();
    req = 2'b00;
    cyc(); cyc();
    #2 rst = 1'b0;
    #1 chk("reset_midburst_outputs", act_vec(), 64'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    compare();
    chk("reset_no_done", {62'd0, done}, 64'd0);
    rst = 1'b1;
    req = 2'b10; set_slot(1, 1'b0, 8'h3C, 10'h020, 8'd2);
    cyc();
    chk("post_reset_gnt1", {62'd0, gnt}, 64'd2);
    wait_idle();

    // Single write: lane 0x0F, 0x010.., len 4.
    req = 2'b01; set_slot(0, 1'b1, 8'h0F, 10'h010, 8'd4);
    for (int k = 0; k < 4; k++) begin
      cyc();
      req = 2'b00;
      chk("wr_addr", {54'd0, mem_w_addr}, {54'd0, wr_lit[k]});
      chk("wr_en", {56'd0, mem_w_en}, 64'h0F);
    end
    cyc();
    chk("wr_done_cycle5", {62'd0, done}, 64'd1);
    wait_idle();

    // Single read with address wrap.
    req = 2'b10; set_slot(1, 1'b0, 8'hA5, 10'h3FE, 8'd3);
    for (int k = 0; k < 3; k++) begin
      cyc();
      req = 2'b00;
      chk("rd_addr", {54'd0, mem_r_addr}, {54'd0, rd_lit[k]});
    end
    cyc();
    chk("rd_drain_rvalid", {62'd0, r_valid}, 64'd2);
    cyc();
    chk("rd_done", {62'd0, done}, 64'd2);
    wait_idle();

    // Contention: both requesting continuously, len 2 each.
    gstarts.delete();
    req = 2'b11;
    set_slot(0, 1'b1, 8'h11, 10'h040, 8'd2);
    set_slot(1, 1'b0, 8'h22, 10'h080, 8'd2);
    for (int n = 0; n < 24; n++) begin
      cyc();
      req_we = 2'($urandom);
      chk("no_rw_overlap", {63'd0, (mem_r_en != '0) && (mem_w_en != '0)}, 64'd0);
    end
    chk("contention_grants", 64'(gstarts.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < gstarts.size(); i++)
      chk("rr_order", {62'd0, gstarts[i]}, {62'd0, g_lit[i]});
    wait_idle();

    // Zero-length burst.
    req = 2'b01; set_slot(0, 1'b0, 8'hFF, 10'h000, 8'd0);
    cyc();
    req = 2'b00;
    chk("len0_gnt_done_busy", {59'd0, gnt, done, busy}, {59'd0, 2'b01, 2'b01, 1'b1});
    chk("len0_no_enables", {48'd0, mem_r_en, mem_w_en}, 64'd0);
    cyc();
    chk("len0_busy_1cycle", {63'd0, busy}, 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cyc();
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
